// File: rtl/ifetch_pkg.sv
// ifetch_pkg -- shared definitions for the instruction fetch slice.
//   ILEN          : instruction width in bits
//   NOP_INSTR     : instruction driven when no fetched instruction is held
//   fetch_state_e : fetch sequencer states
package ifetch_pkg;

  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for I_RUN with an aligned PC
    REQ  = 2'd1,  // request presented, waiting for grant
    WAIT = 2'd2,  // granted, waiting for read data
    HOLD = 2'd3   // instruction presented to decode
  } fetch_state_e;

endpackage

// File: rtl/ifetch_fetch_timer.sv
// fetch_timer -- saturating cycle counter that bounds a bus transaction.
//   CLK       in  clock, rising edge
//   I_RST     in  asynchronous active-low reset
//   I_CLR     in  restart the count at zero (takes priority over I_EN)
//   I_EN      in  count this cycle
//   O_EXPIRED out this is the TIMEOUT-th counted cycle; the transaction
//                 must give up at the coming edge
module fetch_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic CLK,
  input  logic I_RST,
  input  logic I_CLR,
  input  logic I_EN,
  output logic O_EXPIRED
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);

  // Number of cycles already spent in the current transaction.
  logic [CW-1:0] count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge I_RST) begin
    if (!I_RST) begin
      count_q <= '0;
    end else if (I_CLR) begin
      count_q <= '0;
    end else if (I_EN && (count_q != SAT)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // count_q cycles are already used, so the current cycle is the last
  // permitted one once count_q has reached TIMEOUT-1.
  assign O_EXPIRED = (count_q >= LAST);

endmodule

// File: rtl/ifetch.sv
// ifetch -- instruction fetch unit between the PC register and decode.
//   CLK, I_RST            clock (rising edge), async active-low reset
//   I_PC, I_RUN           fetch address and run flag from the PC register
//   I_FLUSH               redirect: abandon the fetch in progress
//   O_MEM_REQ/O_MEM_ADDR  read request to instruction memory
//   I_MEM_GNT             memory accepted the request this cycle
//   I_MEM_RVALID/RDATA    read response
//   O_INSTR/O_INSTR_PC    fetched instruction and its address
//   O_VALID, I_READY      handshake towards decode
//   O_STALL               hold the PC register (combinational)
//   O_FAULT               sticky: misaligned PC or memory timeout
module ifetch #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 16,
  parameter logic [ifetch_pkg::ILEN-1:0] NOP_INSTR = ifetch_pkg::NOP_INSTR
) (
  input  logic                        CLK,
  input  logic                        I_RST,
  input  logic [31:0]                 I_PC,
  input  logic                        I_RUN,
  input  logic                        I_FLUSH,
  output logic                        O_MEM_REQ,
  output logic [AW-1:0]               O_MEM_ADDR,
  input  logic                        I_MEM_GNT,
  input  logic                        I_MEM_RVALID,
  input  logic [ifetch_pkg::ILEN-1:0] I_MEM_RDATA,
  output logic [ifetch_pkg::ILEN-1:0] O_INSTR,
  output logic [31:0]                 O_INSTR_PC,
  output logic                        O_VALID,
  input  logic                        I_READY,
  output logic                        O_STALL,
  output logic                        O_FAULT
);

  import ifetch_pkg::*;

  fetch_state_e    state_q,      state_d;
  logic            mem_req_q,    mem_req_d;
  logic [AW-1:0]   mem_addr_q,   mem_addr_d;
  logic [31:0]     pending_pc_q, pending_pc_d;
  logic [ILEN-1:0] instr_q,      instr_d;
  logic [31:0]     instr_pc_q,   instr_pc_d;
  logic            valid_q,      valid_d;
  logic            fault_q,      fault_d;
  // Set when the in-flight response belongs to a flushed fetch.
  logic            discard_q,    discard_d;

  logic timer_clr;
  logic timer_en;
  logic timer_expired;

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .CLK       (CLK),
    .I_RST     (I_RST),
    .I_CLR     (timer_clr),
    .I_EN      (timer_en),
    .O_EXPIRED (timer_expired)
  );

  always_ff @(posedge CLK or negedge I_RST) begin
    if (!I_RST) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      pending_pc_q <= '0;
      instr_q      <= NOP_INSTR;
      instr_pc_q   <= '0;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      pending_pc_q <= pending_pc_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      valid_q      <= valid_d;
      fault_q      <= fault_d;
      discard_q    <= discard_d;
    end
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    pending_pc_d = pending_pc_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    valid_d      = valid_q;
    fault_d      = fault_q;
    discard_d    = discard_q;
    timer_clr    = 1'b0;
    timer_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (fault_q) begin
          // Faulted: parked until reset.
        end else if (I_RUN && (I_PC[1:0] != 2'b00)) begin
          fault_d = 1'b1;
        end else if (I_RUN) begin
          mem_addr_d   = I_PC[AW-1:0];
          pending_pc_d = I_PC;
          mem_req_d    = 1'b1;
          discard_d    = 1'b0;
          timer_clr    = 1'b1;
          state_d      = REQ;
        end
      end

      REQ: begin
        timer_en = 1'b1;
        // The timeout outranks any handshake seen in the same cycle.
        if (timer_expired) begin
          fault_d   = 1'b1;
          mem_req_d = 1'b0;
          discard_d = 1'b0;
          state_d   = IDLE;
        end else if (I_MEM_GNT) begin
          // A flush coinciding with the grant cannot recall the request,
          // so its response is marked for discard.
          mem_req_d = 1'b0;
          discard_d = I_FLUSH;
          state_d   = WAIT;
        end else if (I_FLUSH) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end

      WAIT: begin
        timer_en = 1'b1;
        if (timer_expired) begin
          fault_d   = 1'b1;
          discard_d = 1'b0;
          state_d   = IDLE;
        end else if (I_MEM_RVALID) begin
          if (discard_q || I_FLUSH) begin
            discard_d = 1'b0;
            state_d   = IDLE;
          end else begin
            instr_d    = I_MEM_RDATA;
            instr_pc_d = pending_pc_q;
            valid_d    = 1'b1;
            state_d    = HOLD;
          end
        end else if (I_FLUSH) begin
          discard_d = 1'b1;
        end
      end

      HOLD: begin
        if (I_FLUSH) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = IDLE;
        end else if (I_READY) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // The PC register may advance only while idle or as HOLD hands off, so its
  // new value is in place when the fetch re-enters IDLE.
  always_comb begin
    O_STALL = 1'b0;
    case (state_q)
      REQ, WAIT: O_STALL = 1'b1;
      HOLD:      O_STALL = !I_READY;
      default:   O_STALL = 1'b0;
    endcase
  end

  assign O_MEM_REQ  = mem_req_q;
  assign O_MEM_ADDR = mem_addr_q;
  assign O_INSTR    = instr_q;
  assign O_INSTR_PC = instr_pc_q;
  assign O_VALID    = valid_q;
  assign O_FAULT    = fault_q;

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch -- directed bench for ifetch. A transaction-level model tracks
// what the fetch unit must be doing (asking, awaiting data, holding an
// instruction) and is compared against the DUT on every falling edge; the
// stimulus process adds hand-computed literal expectations.
module tb_ifetch;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] NOP     = 32'h0000_0000;

  logic        CLK          = 1'b0;
  logic        I_RST        = 1'b0;
  logic [31:0] I_PC         = '0;
  logic        I_RUN        = 1'b0;
  logic        I_FLUSH      = 1'b0;
  logic        I_MEM_GNT    = 1'b0;
  logic        I_MEM_RVALID = 1'b0;
  logic [31:0] I_MEM_RDATA  = '0;
  logic        I_READY      = 1'b0;

  logic        O_MEM_REQ;
  logic [31:0] O_MEM_ADDR;
  logic [31:0] O_INSTR;
  logic [31:0] O_INSTR_PC;
  logic        O_VALID;
  logic        O_STALL;
  logic        O_FAULT;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  ifetch #(
    .AW        (32),
    .TIMEOUT   (TIMEOUT),
    .NOP_INSTR (NOP)
  ) dut (
    .CLK          (CLK),
    .I_RST        (I_RST),
    .I_PC         (I_PC),
    .I_RUN        (I_RUN),
    .I_FLUSH      (I_FLUSH),
    .O_MEM_REQ    (O_MEM_REQ),
    .O_MEM_ADDR   (O_MEM_ADDR),
    .I_MEM_GNT    (I_MEM_GNT),
    .I_MEM_RVALID (I_MEM_RVALID),
    .I_MEM_RDATA  (I_MEM_RDATA),
    .O_INSTR      (O_INSTR),
    .O_INSTR_PC   (O_INSTR_PC),
    .O_VALID      (O_VALID),
    .I_READY      (I_READY),
    .O_STALL      (O_STALL),
    .O_FAULT      (O_FAULT)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit          m_asking;    // request outstanding, no grant yet
  bit          m_awaiting;  // granted, response not yet seen
  bit          m_holding;   // instruction offered to decode
  bit          m_discard;   // response of a flushed fetch still to come
  bit          m_fault;
  int          m_age;       // cycles the current transaction has used
  logic [31:0] m_addr, m_pc, m_instr, m_ipc;

  function automatic void model_reset();
    m_asking = 0; m_awaiting = 0; m_holding = 0; m_discard = 0; m_fault = 0;
    m_age = 0; m_addr = '0; m_pc = '0; m_instr = NOP; m_ipc = '0;
  endfunction

  initial model_reset();

  always @(posedge CLK or negedge I_RST) begin
    if (!I_RST) begin
      model_reset();
    end else if (m_asking || m_awaiting) begin
      m_age = m_age + 1;
      if (m_age == TIMEOUT) begin
        m_fault = 1; m_asking = 0; m_awaiting = 0; m_discard = 0;
      end else if (m_asking) begin
        if (I_MEM_GNT) begin
          m_asking = 0; m_awaiting = 1; m_discard = I_FLUSH;
        end else if (I_FLUSH) begin
          m_asking = 0;
        end
      end else if (I_MEM_RVALID) begin
        if (!m_discard && !I_FLUSH) begin
          m_holding = 1; m_instr = I_MEM_RDATA; m_ipc = m_pc;
        end
        m_awaiting = 0; m_discard = 0;
      end else if (I_FLUSH) begin
        m_discard = 1;
      end
    end else if (m_holding) begin
      if (I_FLUSH) begin
        m_holding = 0; m_instr = NOP;
      end else if (I_READY) begin
        m_holding = 0;
      end
    end else if (!m_fault && I_RUN) begin
      if (I_PC[1:0] != 2'b00) begin
        m_fault = 1;
      end else begin
        m_asking = 1; m_age = 0; m_addr = I_PC; m_pc = I_PC;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    check("cyc_mem_req",  {31'd0, O_MEM_REQ}, {31'd0, m_asking});
    check("cyc_mem_addr", O_MEM_ADDR, m_addr);
    check("cyc_valid",    {31'd0, O_VALID}, {31'd0, m_holding});
    check("cyc_instr",    O_INSTR, m_instr);
    check("cyc_instr_pc", O_INSTR_PC, m_ipc);
    check("cyc_fault",    {31'd0, O_FAULT}, {31'd0, m_fault});
    check("cyc_stall",    {31'd0, O_STALL},
          {31'd0, (m_asking || m_awaiting || (m_holding && !I_READY))});
  end

  // Inputs change 2 time units after each rising edge, well clear of it.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic do_reset();
    I_RST = 1'b0;
    #1;
    check("rst_fault_async", {31'd0, O_FAULT}, 32'd0);
    tick();
    I_RST = 1'b1;
    I_RUN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // ---- reset ----
    tick(2);
    check("rst_instr",    O_INSTR, NOP);
    check("rst_mem_req",  {31'd0, O_MEM_REQ}, 32'd0);
    check("rst_instr_pc", O_INSTR_PC, 32'd0);
    I_RST = 1'b1;

    // ---- zero-wait fetch: cycle 0 IDLE ----
    I_PC = 32'h0; I_RUN = 1'b1; I_READY = 1'b1;
    tick();                                   // cycle 1: REQ
    check("s1_req_c1",  {31'd0, O_MEM_REQ}, 32'd1);
    check("s1_addr_c1", O_MEM_ADDR, 32'h0);
    I_RUN = 1'b0; I_MEM_GNT = 1'b1;
    tick();                                   // cycle 2: WAIT
    I_MEM_GNT = 1'b0; I_MEM_RVALID = 1'b1; I_MEM_RDATA = 32'hDEADBEEF;
    tick();                                   // cycle 3: HOLD
    I_MEM_RVALID = 1'b0;
    check("s1_valid_c3", {31'd0, O_VALID}, 32'd1);
    check("s1_instr_c3", O_INSTR, 32'hDEADBEEF);
    check("s1_ipc_c3",   O_INSTR_PC, 32'h0);
    #1 check("s1_stall_c3", {31'd0, O_STALL}, 32'd0);
    tick();                                   // cycle 4: IDLE
    check("s1_valid_c4", {31'd0, O_VALID}, 32'd0);

    // ---- slow grant, slow data, decode back-pressure ----
    I_PC = 32'h10; I_RUN = 1'b1; I_READY = 1'b0;
    tick();
    I_RUN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("s2_addr_req", O_MEM_ADDR, 32'h10);
      check("s2_stall_req", {31'd0, O_STALL}, 32'd1);
      tick();
    end
    check("s2_addr_gnt", O_MEM_ADDR, 32'h10);
    I_MEM_GNT = 1'b1;
    tick();
    I_MEM_GNT = 1'b0;
    tick();
    I_MEM_RVALID = 1'b1; I_MEM_RDATA = 32'hCAFE0013;
    tick();
    I_MEM_RVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("s2_hold_instr", O_INSTR, 32'hCAFE0013);
      check("s2_hold_stall", {31'd0, O_STALL}, 32'd1);
      tick();
    end
    check("s2_ipc", O_INSTR_PC, 32'h10);
    I_READY = 1'b1;
    #1 check("s2_handoff_stall", {31'd0, O_STALL}, 32'd0);
    tick();
    check("s2_valid_after", {31'd0, O_VALID}, 32'd0);

    // ---- flush in WAIT before data, then a fresh fetch ----
    I_READY = 1'b0;
    I_PC = 32'h20; I_RUN = 1'b1;
    tick();                                   // REQ
    I_RUN = 1'b0; I_MEM_GNT = 1'b1;
    tick();                                   // WAIT
    I_MEM_GNT = 1'b0; I_FLUSH = 1'b1;
    tick();                                   // WAIT, response marked stale
    I_FLUSH = 1'b0; I_MEM_RVALID = 1'b1; I_MEM_RDATA = 32'hBAD0BAD0;
    tick();                                   // IDLE
    I_MEM_RVALID = 1'b0;
    check("s3_valid_dropped", {31'd0, O_VALID}, 32'd0);
    check("s3_instr_kept", O_INSTR, 32'hCAFE0013);
    I_PC = 32'h40; I_RUN = 1'b1;
    tick();
    check("s3_new_addr", O_MEM_ADDR, 32'h40);
    I_RUN = 1'b0; I_MEM_GNT = 1'b1;
    tick();
    I_MEM_GNT = 1'b0; I_MEM_RVALID = 1'b1; I_MEM_RDATA = 32'h12345678;
    tick();                                   // HOLD
    I_MEM_RVALID = 1'b0;
    check("s3_new_instr", O_INSTR, 32'h12345678);
    check("s3_new_ipc", O_INSTR_PC, 32'h40);
    I_FLUSH = 1'b1; I_READY = 1'b1;           // flush outranks ready
    tick();
    I_FLUSH = 1'b0;
    check("s3_hold_flush_nop", O_INSTR, NOP);
    check("s3_hold_flush_valid", {31'd0, O_VALID}, 32'd0);

    // ---- misaligned PC ----
    I_PC = 32'h6; I_RUN = 1'b1;
    tick();
    check("s4_fault", {31'd0, O_FAULT}, 32'd1);
    I_PC = 32'h8;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s4_fault_sticky", {31'd0, O_FAULT}, 32'd1);
      check("s4_no_req", {31'd0, O_MEM_REQ}, 32'd0);
    end
    do_reset();

    // ---- grant never arrives ----
    I_PC = 32'h30; I_RUN = 1'b1;
    tick();                                   // REQ cycle 1
    I_RUN = 1'b0;
    tick(15);                                 // REQ cycle 16
    check("s5_req_c16", {31'd0, O_MEM_REQ}, 32'd1);
    check("s5_nofault_c16", {31'd0, O_FAULT}, 32'd0);
    tick();
    check("s5_timeout_fault", {31'd0, O_FAULT}, 32'd1);
    check("s5_timeout_req", {31'd0, O_MEM_REQ}, 32'd0);
    I_MEM_RVALID = 1'b1; I_MEM_RDATA = 32'h55555555;
    tick();
    I_MEM_RVALID = 1'b0;
    check("s5_late_rvalid", {31'd0, O_VALID}, 32'd0);
    check("s5_late_instr", O_INSTR, NOP);
    do_reset();

    // ---- async reset while waiting for data ----
    I_PC = 32'h50; I_RUN = 1'b1;
    tick();
    I_RUN = 1'b0; I_MEM_GNT = 1'b1;
    tick();                                   // WAIT
    I_MEM_GNT = 1'b0;
    #1 I_RST = 1'b0;
    #1;
    check("s6_rst_addr",  O_MEM_ADDR, 32'h0);
    check("s6_rst_stall", {31'd0, O_STALL}, 32'd0);
    check("s6_rst_valid", {31'd0, O_VALID}, 32'd0);
    tick();
    I_RST = 1'b1;
    I_MEM_RVALID = 1'b1; I_MEM_RDATA = 32'h77777777;
    tick();
    I_MEM_RVALID = 1'b0;
    check("s6_stale_valid", {31'd0, O_VALID}, 32'd0);
    check("s6_stale_instr", O_INSTR, NOP);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
